uart_baud_gen_os: RTL and testbench

//  Parametrised successor baud generator for the UART TX/RX pair.

---
 rtl/uart_baud_gen_os_if.sv | 34 +++
 rtl/uart_baud_gen_os.sv | 183 ++++++++++++++++++
 tb/tb_uart_baud_gen_os.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_os_if.sv
// uart_baud_gen_os_if
//   Bundles the configuration inputs and strobe outputs of the UART baud
//   generator.
//   master : drives enable, sel, div_custom, restart; receives os_tick, tick, err
//   slave  : the generator itself (mirror directions)
//   Signals:
//     enable      1         run the counters when high
//     sel         3         baud select (table entries, custom, invalid)
//     div_custom  DIV_W+4   custom os divisor, [DIV_W+3:4] integer, [3:0] sixteenths
//     restart     1         single-cycle phase re-align pulse
//     os_tick     1         oversample strobe
//     tick        1         1x baud strobe, always coincident with an os_tick
//     err         1         configuration error flag
interface uart_baud_gen_os_if #(
   parameter int DIV_W = 16
);
   logic             enable;
   logic [2:0]       sel;
   logic [DIV_W+3:0] div_custom;
   logic             restart;
   logic             os_tick;
   logic             tick;
   logic             err;

   modport master (
      output enable, sel, div_custom, restart,
      input  os_tick, tick, err
   );

   modport slave (
      input  enable, sel, div_custom, restart,
      output os_tick, tick, err
   );
endinterface

// File: rtl/uart_baud_gen_os.sv
// uart_baud_gen_os
//   Baud generator for the UART TX/RX pair. Produces an oversample strobe
//   (os_tick, OS_RATE per baud period) for the receiver and a 1x strobe
//   (tick) for the transmitter. The baud is picked from a six-entry table
//   or from a runtime custom divisor; restart re-aligns the phase on an RX
//   start-bit detect. Single clock domain.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   uart_baud_gen_os_if.slave (enable, sel, div_custom, restart in;
//           os_tick, tick, err out)
//   Optional feature macro: UART_BAUD_FRAC_EN enables fractional dithering
//   of the os period (P alternates between N and N+1 so that every 16 os
//   periods contain exactly F long ones). Without it P=N and all fraction
//   bits are ignored.
//   Strobe protocol: os_tick and tick are single-cycle, registered pulses
//   with no back-pressure; a consumer must sample them every clock. There
//   is no valid/ready pair on this block.
module uart_baud_gen_os #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int OS_RATE  = 16,
   parameter int DIV_W    = 16
) (
   input logic               clk,
   input logic               rst,
   uart_baud_gen_os_if.slave bus
);
   localparam int PH_W = $clog2(OS_RATE);

   // Integer part of the os divisor for a table baud; a fraction that
   // rounds up to 16/16 is folded into the integer.
   function automatic logic [DIV_W-1:0] tbl_n(input int baud);
      longint d, n, r, f;
      d = longint'(baud) * longint'(OS_RATE);
      n = longint'(CLK_FREQ) / d;
      r = longint'(CLK_FREQ) % d;
      f = (r * 32 + d) / (2 * d);
      if (f >= 16) n = n + 1;
      return n[DIV_W-1:0];
   endfunction

   localparam logic [DIV_W-1:0] N_4800   = tbl_n(4800);
   localparam logic [DIV_W-1:0] N_9600   = tbl_n(9600);
   localparam logic [DIV_W-1:0] N_19200  = tbl_n(19200);
   localparam logic [DIV_W-1:0] N_38400  = tbl_n(38400);
   localparam logic [DIV_W-1:0] N_57600  = tbl_n(57600);
   localparam logic [DIV_W-1:0] N_115200 = tbl_n(115200);

   logic [2:0]       sel_q;
   logic [DIV_W-1:0] div_n_q;
   logic [DIV_W-1:0] n_cur;
   logic [DIV_W:0]   p_cur;
   logic [DIV_W:0]   os_cnt;
   logic [PH_W-1:0]  ph_cnt;
   logic             os_tick_q;
   logic             tick_q;
   logic             err_q;
   logic             cfg_bad;
   logic             hold;
   logic             period_end;

`ifdef UART_BAUD_FRAC_EN
   // Rounded sixteenths of the os divisor; saturates to 0 when the
   // integer part absorbed the carry.
   function automatic logic [3:0] tbl_f(input int baud);
      longint d, r, f;
      d = longint'(baud) * longint'(OS_RATE);
      r = longint'(CLK_FREQ) % d;
      f = (r * 32 + d) / (2 * d);
      if (f >= 16) f = 0;
      return f[3:0];
   endfunction

   localparam logic [3:0] F_4800   = tbl_f(4800);
   localparam logic [3:0] F_9600   = tbl_f(9600);
   localparam logic [3:0] F_19200  = tbl_f(19200);
   localparam logic [3:0] F_38400  = tbl_f(38400);
   localparam logic [3:0] F_57600  = tbl_f(57600);
   localparam logic [3:0] F_115200 = tbl_f(115200);

   logic [3:0] div_f_q;
   logic [3:0] f_cur;
   logic [3:0] frac_acc;
   logic [4:0] frac_sum;

   always_comb begin
      f_cur = 4'd0;
      case (sel_q)
         3'd0:    f_cur = F_4800;
         3'd1:    f_cur = F_9600;
         3'd2:    f_cur = F_19200;
         3'd3:    f_cur = F_38400;
         3'd4:    f_cur = F_57600;
         3'd5:    f_cur = F_115200;
         3'd6:    f_cur = div_f_q;
         default: f_cur = 4'd0;
      endcase
   end

   // The carry of the pending accumulation decides the current period's
   // length, so any 16 consecutive periods hold exactly F long ones.
   assign frac_sum = {1'b0, frac_acc} + {1'b0, f_cur};
   assign p_cur    = {1'b0, n_cur} + {{DIV_W{1'b0}}, frac_sum[4]};
`else
   // Fraction bits have no effect when dithering is compiled out.
   logic unused_frac_bits;
   assign unused_frac_bits = ^bus.div_custom[3:0];
   assign p_cur = {1'b0, n_cur};
`endif

   always_comb begin
      n_cur = '0;
      case (sel_q)
         3'd0:    n_cur = N_4800;
         3'd1:    n_cur = N_9600;
         3'd2:    n_cur = N_19200;
         3'd3:    n_cur = N_38400;
         3'd4:    n_cur = N_57600;
         3'd5:    n_cur = N_115200;
         3'd6:    n_cur = div_n_q;
         default: n_cur = '0;
      endcase
   end

   // Invalid configuration judged on the raw inputs so err lines up with
   // sel_q/div_q, and so no strobe slips out on the edge err rises.
   assign cfg_bad = (bus.sel == 3'b111) ||
                    ((bus.sel == 3'b110) && (bus.div_custom[DIV_W+3:4] < DIV_W'(2)));

   // Any of these forces the counters to 0 on the next edge. restart
   // outranks a period end, so a coincident restart suppresses the strobe.
   assign hold = !bus.enable || bus.restart || err_q || cfg_bad || (bus.sel != sel_q);

   // >= rather than == keeps the counter sane if the custom divisor shrinks
   // below the current count mid-period.
   assign period_end = (os_cnt >= (p_cur - (DIV_W+1)'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q     <= 3'b000;
         div_n_q   <= '0;
         os_cnt    <= '0;
         ph_cnt    <= '0;
         os_tick_q <= 1'b0;
         tick_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
         div_f_q   <= 4'd0;
         frac_acc  <= 4'd0;
`endif
      end else begin
         sel_q     <= bus.sel;
         div_n_q   <= bus.div_custom[DIV_W+3:4];
         err_q     <= cfg_bad;
         os_tick_q <= 1'b0;
         tick_q    <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
         div_f_q   <= bus.div_custom[3:0];
`endif
         if (hold) begin
            os_cnt <= '0;
            ph_cnt <= '0;
`ifdef UART_BAUD_FRAC_EN
            frac_acc <= 4'd0;
`endif
         end else if (period_end) begin
            os_cnt    <= '0;
            os_tick_q <= 1'b1;
            ph_cnt    <= ph_cnt + PH_W'(1);
            tick_q    <= (ph_cnt == PH_W'(OS_RATE - 1));
`ifdef UART_BAUD_FRAC_EN
            frac_acc  <= frac_sum[3:0];
`endif
         end else begin
            os_cnt <= os_cnt + (DIV_W+1)'(1);
         end
      end
   end

   assign bus.os_tick = os_tick_q;
   assign bus.tick    = tick_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_baud_gen_os.sv
// tb_uart_baud_gen_os
//   Directed table of baud configurations with hand-computed os/tick
//   periods (CLK_FREQ=100 MHz, OS_RATE=16), followed by hand-written
//   sequences for reset, restart alignment, enable and mid-period reset.
module tb_uart_baud_gen_os;
   localparam int DIV_W = 16;

   logic clk = 1'b0;
   logic rst;

   int n_vec = 0;
   int n_miss = 0;

   uart_baud_gen_os_if #(.DIV_W(DIV_W)) bus ();

   uart_baud_gen_os #(
      .CLK_FREQ(100_000_000),
      .OS_RATE (16),
      .DIV_W   (DIV_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      int         n_div;   // custom integer divisor
      bit         exp_err;
      int         os1;     // edges from config edge to first os_tick
      int         os2;     // second os period
      int         tk;      // first tick latency and tick period
   } vec_t;

   vec_t v[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Steps until the chosen strobe is seen; n=-1 when the budget runs out.
   task automatic wait_evt(input bit for_tick, input int budget,
                           output int n, output int os_seen, output int os_at_hit);
      n = 0;
      os_seen = 0;
      os_at_hit = 0;
      for (int k = 0; k < budget; k++) begin
         step();
         n++;
         if (bus.os_tick) os_seen++;
         if (for_tick ? bus.tick : bus.os_tick) begin
            os_at_hit = int'(bus.os_tick);
            return;
         end
      end
      n = -1;
   endtask

   task automatic count_strobes(input int cycles, output int cnt);
      cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (bus.os_tick || bus.tick) cnt++;
      end
   endtask

   initial begin
      int n1, n2, n3, n4, seen, coinc, cnt;
      logic [DIV_W-1:0] nd;

      // sel, N, err, os1, os2, tick
`ifdef UART_BAUD_FRAC_EN
      v[0] = '{3'b001, 0,  1'b0, 651, 651, 10417};
      v[1] = '{3'b101, 0,  1'b0, 54,  54,  868};
      v[6] = '{3'b010, 0,  1'b0, 325, 326, 5208};
`else
      v[0] = '{3'b001, 0,  1'b0, 651, 651, 10416};
      v[1] = '{3'b101, 0,  1'b0, 54,  54,  864};
      v[6] = '{3'b010, 0,  1'b0, 325, 325, 5200};
`endif
      v[2] = '{3'b111, 0,  1'b1, 0,   0,   0};
      v[3] = '{3'b110, 10, 1'b0, 10,  10,  160};
      v[4] = '{3'b110, 1,  1'b1, 0,   0,   0};
      v[5] = '{3'b110, 2,  1'b0, 2,   2,   32};

      // Reset state
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.sel = 3'b000;
      bus.div_custom = '0;
      bus.restart = 1'b0;
      repeat (3) step();
      check("rst_os_tick", int'(bus.os_tick), 0);
      check("rst_tick", int'(bus.tick), 0);
      check("rst_err", int'(bus.err), 0);
      rst = 1'b0;
      count_strobes(1000, cnt);
      check("idle_strobes", cnt, 0);
      check("idle_err", int'(bus.err), 0);

      // Table-driven configurations
      for (int i = 0; i < 7; i++) begin
         nd = v[i].n_div[DIV_W-1:0];
         bus.sel = v[i].sel;
         bus.div_custom = {nd, 4'd0};
         bus.enable = 1'b1;
         step();
         check($sformatf("v%0d_err", i), int'(bus.err), int'(v[i].exp_err));
         if (v[i].exp_err) begin
            count_strobes(200, cnt);
            check($sformatf("v%0d_err_strobes", i), cnt, 0);
         end else begin
            wait_evt(1'b0, 2 * v[i].os1 + 20, n1, seen, coinc);
            check($sformatf("v%0d_os_first", i), n1, v[i].os1);
            wait_evt(1'b0, 2 * v[i].os2 + 20, n2, seen, coinc);
            check($sformatf("v%0d_os_period", i), n2, v[i].os2);
            wait_evt(1'b1, 2 * v[i].tk + 20, n3, seen, coinc);
            check($sformatf("v%0d_tick_first", i), n1 + n2 + n3, v[i].tk);
            check($sformatf("v%0d_tick_coinc", i), coinc, 1);
            wait_evt(1'b1, 2 * v[i].tk + 20, n4, seen, coinc);
            check($sformatf("v%0d_tick_period", i), n4, v[i].tk);
            check($sformatf("v%0d_os_per_tick", i), seen, 16);
         end
      end

      // Restart mid-period on sel=010: full os and tick periods follow
      repeat (100) step();
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      wait_evt(1'b0, 700, n1, seen, coinc);
      check("restart_os", n1, 325);
      wait_evt(1'b1, 11000, n2, seen, coinc);
`ifdef UART_BAUD_FRAC_EN
      check("restart_tick", n1 + n2, 5208);
`else
      check("restart_tick", n1 + n2, 5200);
`endif

      // Restart landing on os_cnt==P-1 suppresses that strobe
      bus.sel = 3'b110;
      bus.div_custom = {16'd10, 4'd0};
      step();
      wait_evt(1'b0, 40, n1, seen, coinc);
      check("coinc_setup_os", n1, 10);
      repeat (9) step();
      bus.restart = 1'b1;
      step();
      check("coinc_no_strobe", int'(bus.os_tick), 0);
      bus.restart = 1'b0;
      wait_evt(1'b0, 40, n2, seen, coinc);
      check("coinc_next_os", n2, 10);

      // enable=0: no strobes, err still tracks config
      bus.enable = 1'b0;
      bus.sel = 3'b111;
      step();
      check("dis_err", int'(bus.err), 1);
      count_strobes(100, cnt);
      check("dis_strobes", cnt, 0);

      // Reset mid-run; sel_q returns to 000 so the first edge after
      // release sees a sel change, adding one edge to the first period.
      bus.sel = 3'b110;
      bus.div_custom = {16'd10, 4'd0};
      bus.enable = 1'b1;
      step();
      repeat (5) step();
      rst = 1'b1;
      step();
      check("mrst_os_tick", int'(bus.os_tick), 0);
      check("mrst_err", int'(bus.err), 0);
      rst = 1'b0;
      wait_evt(1'b0, 40, n1, seen, coinc);
      check("mrst_first_os", n1, 11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
